psum_out_ctrl: RTL and testbench

Sequencing controller for the psum output path. It accepts 1-bit results from psum_adder and forwards them to the bit packager, counting channels and output pixels. It generates the packager's layer-finish strobe and buffers packaged words in a small FIFO ahead of the AXIS master. When the FIFO nears full it back-pressures psum_adder, so no word is lost while downstream deasserts tready.

---
 rtl/psum_out_ctrl_pkg.sv | 17 +
 rtl/psum_out_ctrl_if.sv | 23 ++
 rtl/psum_out_ctrl_fifo.sv | 72 +++++++
 rtl/psum_out_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_psum_out_ctrl.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/psum_out_ctrl_pkg.sv
// Shared definitions for the psum output path controller: FSM encoding, op codes, counter widths.
package psum_out_defs;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Op code that makes the packager flush a partial word at layer end.
    localparam logic [1:0] OP_FLUSH = 2'd0;

    localparam int CH_W = 12;
    localparam int PX_W = 16;

endpackage : psum_out_defs

// File: rtl/psum_out_ctrl_if.sv
// AXI-Stream style bundle carrying packaged words out of the controller.
interface psum_out_ctrl_if #(
    parameter int DW = 32
);
    logic          tvalid;
    logic [DW-1:0] tdata;
    logic          tlast;
    logic          tready;

    modport master (
        output tvalid,
        output tdata,
        output tlast,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tlast,
        output tready
    );
endinterface : psum_out_ctrl_if

// File: rtl/psum_out_ctrl_fifo.sv
// Small synchronous FIFO with occupancy count; head is presented combinationally so
// the AXIS data stays stable while the consumer stalls.
module psum_out_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             overflow
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_wr;
    logic             do_rd;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign do_rd    = rd_en & ~empty;
    // A write into a full FIFO only lands if a read frees the slot in the same cycle.
    assign do_wr    = wr_en & (~full | do_rd);
    assign overflow = wr_en & full & ~do_rd;
    assign count    = count_q;
    assign rd_data  = mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

endmodule : psum_out_fifo

// File: rtl/psum_out_ctrl.sv
// Sequences psum bits into the packager, counts channels/pixels and buffers packaged words.
// Optional PSUM_OUT_CTRL_STATS_EN adds stall_cycles / word_count statistics outputs.
module psum_out_ctrl
    import psum_out_defs::*;
#(
    parameter int C_M_AXIS_TDATA_WIDTH = 32,
    parameter int FIFO_DEPTH           = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic [1:0]                      operation,
    input  logic [CH_W-1:0]                 output_channel_size,
    input  logic [PX_W-1:0]                 out_pixel_num,
    input  logic                            psum_valid,
    input  logic                            psum_data,
    output logic                            psum_ready,
    output logic                            pkg_in_valid,
    output logic                            pkg_in_data,
    output logic                            pkg_layer_finish,
    output logic [1:0]                      pkg_operation,
    output logic [CH_W-1:0]                 pkg_channel_size,
    input  logic                            pkg_out_valid,
    input  logic                            pkg_out_last,
    input  logic [C_M_AXIS_TDATA_WIDTH-1:0] pkg_out_data,
    psum_out_ctrl_if.master                 m_axis,
    output logic                            busy,
    output logic                            done,
    output logic                            err_overflow
`ifdef PSUM_OUT_CTRL_STATS_EN
    ,
    output logic [31:0]                     stall_cycles,
    output logic [31:0]                     word_count
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_e          state_q, state_d;
    logic [CH_W-1:0] ch_cnt_q, ch_cnt_d;
    logic [PX_W-1:0] px_cnt_q, px_cnt_d;
    logic [1:0]      op_q, op_d;
    logic [CH_W-1:0] size_q, size_d;
    logic [PX_W-1:0] pix_q, pix_d;
    logic            last_seen_q, last_seen_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic            accept;
    logic            ch_wrap;
    logic            last_bit;
    logic            fifo_rd;
    logic [CW-1:0]   fifo_count;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_ovf;

    // Keep one slot free for the word still inside the 1-cycle packager.
    assign psum_ready       = (state_q == ST_RUN) && (fifo_count <= CW'(FIFO_DEPTH - 2));
    assign accept           = psum_valid & psum_ready;
    assign ch_wrap          = (ch_cnt_q == size_q - 1'b1);
    assign last_bit         = ch_wrap && (px_cnt_q == pix_q - 1'b1);

    assign pkg_in_valid     = accept;
    assign pkg_in_data      = psum_data;
    assign pkg_layer_finish = accept & last_bit;
    assign pkg_operation    = op_q;
    assign pkg_channel_size = size_q;

    assign busy             = (state_q != ST_IDLE);
    assign done             = done_q;
    assign err_overflow     = err_q;

    assign fifo_rd          = m_axis.tvalid & m_axis.tready;
    assign m_axis.tvalid    = ~fifo_empty;

    psum_out_fifo #(
        .WIDTH (C_M_AXIS_TDATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (pkg_out_valid),
        .wr_data  ({pkg_out_last, pkg_out_data}),
        .rd_en    (fifo_rd),
        .rd_data  ({m_axis.tlast, m_axis.tdata}),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .overflow (fifo_ovf)
    );

    always_comb begin
        state_d     = state_q;
        ch_cnt_d    = ch_cnt_q;
        px_cnt_d    = px_cnt_q;
        op_d        = op_q;
        size_d      = size_q;
        pix_d       = pix_q;
        last_seen_d = last_seen_q;
        done_d      = 1'b0;
        err_d       = err_q | fifo_ovf;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d        = operation;
                    size_d      = output_channel_size;
                    pix_d       = out_pixel_num;
                    ch_cnt_d    = '0;
                    px_cnt_d    = '0;
                    last_seen_d = 1'b0;
                    if ((output_channel_size == '0) || (out_pixel_num == '0)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (accept) begin
                    if (ch_wrap) begin
                        ch_cnt_d = '0;
                        px_cnt_d = px_cnt_q + 1'b1;
                    end else begin
                        ch_cnt_d = ch_cnt_q + 1'b1;
                    end
                    if (last_bit) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (last_seen_q && fifo_empty) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The final word only counts once it has actually been stored.
        if ((state_q != ST_IDLE) && pkg_out_valid && pkg_out_last && !fifo_ovf) begin
            last_seen_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ch_cnt_q    <= '0;
            px_cnt_q    <= '0;
            op_q        <= '0;
            size_q      <= '0;
            pix_q       <= '0;
            last_seen_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_cnt_q    <= ch_cnt_d;
            px_cnt_q    <= px_cnt_d;
            op_q        <= op_d;
            size_q      <= size_d;
            pix_q       <= pix_d;
            last_seen_q <= last_seen_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

`ifdef PSUM_OUT_CTRL_STATS_EN
    logic [31:0] stall_q, stall_d;
    logic [31:0] words_q, words_d;

    always_comb begin
        stall_d = stall_q;
        words_d = words_q;
        if ((state_q == ST_IDLE) && start) begin
            stall_d = '0;
            words_d = '0;
        end else begin
            if ((state_q == ST_RUN) && psum_valid && !psum_ready) begin
                stall_d = stall_q + 1'b1;
            end
            if (fifo_rd) begin
                words_d = words_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
            words_q <= '0;
        end else begin
            stall_q <= stall_d;
            words_q <= words_d;
        end
    end

    assign stall_cycles = stall_q;
    assign word_count   = words_q;
`endif

endmodule : psum_out_ctrl

// File: tb/tb_psum_out_ctrl.sv
// Bench for psum_out_ctrl: models the 1-cycle bit packager and scoreboards AXIS words.
module tb_psum_out_ctrl;
    import psum_out_defs::*;

    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [1:0]      operation;
    logic [11:0]     output_channel_size;
    logic [15:0]     out_pixel_num;
    logic            psum_valid;
    logic            psum_data;
    logic            psum_ready;
    logic            pkg_in_valid;
    logic            pkg_in_data;
    logic            pkg_layer_finish;
    logic [1:0]      pkg_operation;
    logic [11:0]     pkg_channel_size;
    logic            pkg_out_valid;
    logic            pkg_out_last;
    logic [DW-1:0]   pkg_out_data;
    logic            busy;
    logic            done;
    logic            err_overflow;
`ifdef PSUM_OUT_CTRL_STATS_EN
    logic [31:0]     stall_cycles;
    logic [31:0]     word_count;
`endif

    psum_out_ctrl_if #(.DW(DW)) m_axis_if ();

    always #5 clk = ~clk;

    psum_out_ctrl #(
        .C_M_AXIS_TDATA_WIDTH (DW),
        .FIFO_DEPTH           (DEPTH)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .start               (start),
        .operation           (operation),
        .output_channel_size (output_channel_size),
        .out_pixel_num       (out_pixel_num),
        .psum_valid          (psum_valid),
        .psum_data           (psum_data),
        .psum_ready          (psum_ready),
        .pkg_in_valid        (pkg_in_valid),
        .pkg_in_data         (pkg_in_data),
        .pkg_layer_finish    (pkg_layer_finish),
        .pkg_operation       (pkg_operation),
        .pkg_channel_size    (pkg_channel_size),
        .pkg_out_valid       (pkg_out_valid),
        .pkg_out_last        (pkg_out_last),
        .pkg_out_data        (pkg_out_data),
        .m_axis              (m_axis_if),
        .busy                (busy),
        .done                (done),
        .err_overflow        (err_overflow)
`ifdef PSUM_OUT_CTRL_STATS_EN
        ,
        .stall_cycles        (stall_cycles),
        .word_count          (word_count)
`endif
    );

    int checks = 0;
    int errors = 0;

    int acc_bits, lf_count, lf_at, done_count, beats, last_beats, tb_cnt;
    logic [DW:0]   exp_q [$];
    logic [DW:0]   exp_w;
    logic [DW-1:0] pack_buf;
    int            pack_n;
    logic          stage_v, stage_last, force_v;
    logic [DW-1:0] stage_data;

    // Monitor: packager model, scoreboard and occupancy tracking, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (psum_valid && psum_ready) begin
                checks++;
                if (pkg_in_valid !== 1'b1 || pkg_in_data !== psum_data) begin
                    errors++;
                    $display("FAIL passthru got v=%b d=%b exp v=1 d=%b", pkg_in_valid, pkg_in_data, psum_data);
                end
                acc_bits++;
                pack_buf[pack_n] = psum_data;
                pack_n++;
                if (pkg_layer_finish) begin
                    lf_count++;
                    lf_at = acc_bits;
                end
                if (pack_n == DW || pkg_layer_finish) begin
                    stage_v    = 1'b1;
                    stage_last = pkg_layer_finish;
                    stage_data = pack_buf;
                    exp_q.push_back({pkg_layer_finish, pack_buf});
                    pack_buf = '0;
                    pack_n   = 0;
                end
            end else if (pkg_in_valid !== 1'b0 || pkg_layer_finish !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL spurious_pkg got v=%b lf=%b exp 0 0", pkg_in_valid, pkg_layer_finish);
            end
            if (done) done_count++;
            if (m_axis_if.tvalid && m_axis_if.tready) begin
                beats++;
                if (m_axis_if.tlast) last_beats++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL axis_beat got %h exp none", {m_axis_if.tlast, m_axis_if.tdata});
                end else begin
                    exp_w = exp_q.pop_front();
                    if ({m_axis_if.tlast, m_axis_if.tdata} !== exp_w) begin
                        errors++;
                        $display("FAIL axis_beat got %h exp %h", {m_axis_if.tlast, m_axis_if.tdata}, exp_w);
                    end else begin
                        $display("beat %0d data=%h last=%b", beats, m_axis_if.tdata, m_axis_if.tlast);
                    end
                end
            end
            if (pkg_out_valid && !(m_axis_if.tvalid && m_axis_if.tready) && tb_cnt < DEPTH) tb_cnt++;
            else if (!pkg_out_valid && m_axis_if.tvalid && m_axis_if.tready) tb_cnt--;
        end
    end

    // Packager output: word appears the cycle after its final bit was accepted.
    always @(posedge clk) begin
        #1;
        pkg_out_valid = stage_v | force_v;
        pkg_out_last  = stage_v & stage_last;
        pkg_out_data  = stage_v ? stage_data : 32'hDEAD_BEEF;
        stage_v       = 1'b0;
    end

    task automatic clr_stats();
        acc_bits = 0; lf_count = 0; lf_at = 0; done_count = 0; beats = 0; last_beats = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        exp_q.delete();
        pack_buf = '0; pack_n = 0; stage_v = 1'b0; force_v = 1'b0; tb_cnt = 0;
        @(posedge clk); #1;
    endtask

    task automatic start_layer(input logic [1:0] op, input int size, input int pix);
        @(posedge clk); #1;
        operation = op; output_channel_size = 12'(size); out_pixel_num = 16'(pix);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic feed_to(input int target, input int max_cyc);
        int n = 0;
        while (acc_bits < target && n < max_cyc) begin
            psum_valid = 1'b1;
            psum_data  = 1'($urandom);
            @(posedge clk); #1;
            n++;
        end
        psum_valid = 1'b0;
        checks++;
        if (acc_bits != target) begin
            errors++;
            $display("FAIL feed_bits got %0d exp %0d", acc_bits, target);
        end
    endtask

    task automatic wait_done(input int max_cyc);
        int n = 0;
        int base = done_count;
        while (done_count == base && n < max_cyc) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (done_count == base) begin
            errors++;
            $display("FAIL done_timeout got 0 pulses exp 1 within %0d cycles", max_cyc);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({psum_ready, busy, done, m_axis_if.tvalid, err_overflow, pkg_in_valid,
             pkg_layer_finish, pkg_operation, pkg_channel_size} !== 21'd0) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%b busy=%b done=%b tv=%b err=%b op=%0d cs=%0d exp all 0",
                     psum_ready, busy, done, m_axis_if.tvalid, err_overflow, pkg_operation, pkg_channel_size);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || psum_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset got busy=%b rdy=%b exp 0 0", busy, psum_ready);
        end
        $display("test_reset complete");
    endtask

    task automatic test_basic();
        clr_stats();
        m_axis_if.tready = 1'b1;
        start_layer(2'd0, 35, 2);
        checks++;
        if (busy !== 1'b1 || psum_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_run got busy=%b rdy=%b exp 1 1", busy, psum_ready);
        end
        feed_to(70, 200);
        wait_done(50);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (lf_count != 1 || lf_at != 70) begin
            errors++;
            $display("FAIL basic_lf got count=%0d at=%0d exp 1 at 70", lf_count, lf_at);
        end
        checks++;
        if (beats != 3 || last_beats != 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL basic_beats got %0d last=%0d left=%0d exp 3 1 0", beats, last_beats, exp_q.size());
        end
        checks++;
        if (done_count != 1 || busy !== 1'b0 || err_overflow !== 1'b0) begin
            errors++;
            $display("FAIL basic_end got done=%0d busy=%b err=%b exp 1 0 0", done_count, busy, err_overflow);
        end
        checks++;
        if (pkg_channel_size !== 12'd35 || pkg_operation !== 2'd0) begin
            errors++;
            $display("FAIL basic_cfg got cs=%0d op=%0d exp 35 0", pkg_channel_size, pkg_operation);
        end
        $display("test_basic complete");
    endtask

    task automatic test_backpressure();
        int n = 0;
        clr_stats();
        m_axis_if.tready = 1'b0;
        start_layer(2'd0, 32, 4);
        psum_valid = 1'b1;
        while (psum_ready !== 1'b0 && n < 300) begin
            psum_data = 1'($urandom);
            @(posedge clk); #1;
            n++;
        end
        repeat (5) begin
            psum_data = 1'($urandom);
            @(posedge clk); #1;
        end
        checks++;
        if (acc_bits != 97 || tb_cnt != DEPTH - 1 || psum_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_stall got bits=%0d fifo=%0d rdy=%b exp 97 %0d 0", acc_bits, tb_cnt, psum_ready, DEPTH - 1);
        end
        m_axis_if.tready = 1'b1;
        feed_to(128, 300);
        wait_done(50);
        checks++;
        if (beats != 4 || last_beats != 1 || exp_q.size() != 0 || err_overflow !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain got beats=%0d last=%0d left=%0d err=%b exp 4 1 0 0",
                     beats, last_beats, exp_q.size(), err_overflow);
        end
        $display("test_backpressure complete");
    endtask

    task automatic test_zero_size();
        clr_stats();
        m_axis_if.tready = 1'b1;
        psum_valid = 1'b1;
        @(posedge clk); #1;
        operation = 2'd0; output_channel_size = 12'd8; out_pixel_num = 16'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL zero_c1 got done=%b busy=%b exp 0 1", done, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL zero_c2 got done=%b exp 1", done);
        end
        repeat (3) @(posedge clk);
        #1;
        psum_valid = 1'b0;
        checks++;
        if (acc_bits != 0 || beats != 0 || done_count != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_end got bits=%0d beats=%0d done=%0d busy=%b exp 0 0 1 0",
                     acc_bits, beats, done_count, busy);
        end
        $display("test_zero_size complete");
    endtask

    task automatic test_restart_ignored();
        clr_stats();
        m_axis_if.tready = 1'b1;
        start_layer(2'd0, 8, 4);
        feed_to(10, 50);
        operation = 2'd2; output_channel_size = 12'd3; out_pixel_num = 16'd1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (pkg_channel_size !== 12'd8 || pkg_operation !== 2'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL restart_cfg got cs=%0d op=%0d busy=%b exp 8 0 1", pkg_channel_size, pkg_operation, busy);
        end
        feed_to(32, 100);
        wait_done(50);
        checks++;
        if (lf_at != 32 || lf_count != 1 || beats != 1 || last_beats != 1) begin
            errors++;
            $display("FAIL restart_end got lf_at=%0d lf=%0d beats=%0d last=%0d exp 32 1 1 1",
                     lf_at, lf_count, beats, last_beats);
        end
        $display("test_restart_ignored complete");
    endtask

    task automatic test_reset_mid();
        int n = 0;
        clr_stats();
        m_axis_if.tready = 1'b0;
        start_layer(2'd0, 35, 4);
        while (tb_cnt < 2 && n < 200) begin
            psum_valid = 1'b1;
            psum_data  = 1'($urandom);
            @(posedge clk); #1;
            n++;
        end
        psum_valid = 1'b0;
        checks++;
        if (m_axis_if.tvalid !== 1'b1 || tb_cnt != 2) begin
            errors++;
            $display("FAIL mid_fill got tv=%b fifo=%0d exp 1 2", m_axis_if.tvalid, tb_cnt);
        end
        do_reset();
        checks++;
        if (busy !== 1'b0 || m_axis_if.tvalid !== 1'b0 || psum_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got busy=%b tv=%b rdy=%b exp 0 0 0", busy, m_axis_if.tvalid, psum_ready);
        end
        rst_n = 1'b1;
        clr_stats();
        m_axis_if.tready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (beats != 0) begin
            errors++;
            $display("FAIL mid_no_beats got %0d exp 0", beats);
        end
        start_layer(2'd0, 8, 1);
        feed_to(8, 50);
        wait_done(50);
        checks++;
        if (lf_at != 8 || beats != 1 || last_beats != 1) begin
            errors++;
            $display("FAIL mid_after got lf_at=%0d beats=%0d last=%0d exp 8 1 1", lf_at, beats, last_beats);
        end
        $display("test_reset_mid complete");
    endtask

    task automatic test_overflow();
        int n = 0;
        clr_stats();
        m_axis_if.tready = 1'b0;
        start_layer(2'd0, 32, 4);
        psum_valid = 1'b1;
        while (psum_ready !== 1'b0 && n < 300) begin
            psum_data = 1'($urandom);
            @(posedge clk); #1;
            n++;
        end
        psum_valid = 1'b0;
        @(negedge clk); force_v = 1'b1;
        @(negedge clk); force_v = 1'b0;
        @(negedge clk);
        checks++;
        if (err_overflow !== 1'b0 || tb_cnt != DEPTH) begin
            errors++;
            $display("FAIL ovf_fill got err=%b fifo=%0d exp 0 %0d", err_overflow, tb_cnt, DEPTH);
        end
        force_v = 1'b1;
        @(negedge clk); force_v = 1'b0;
        @(negedge clk);
        checks++;
        if (err_overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set got %b exp 1", err_overflow);
        end
        repeat (6) @(negedge clk);
        checks++;
        if (err_overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky got %b exp 1", err_overflow);
        end
        do_reset();
        rst_n = 1'b1;
        checks++;
        if (err_overflow !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear got err=%b busy=%b exp 0 0", err_overflow, busy);
        end
        $display("test_overflow complete");
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; operation = '0; output_channel_size = '0; out_pixel_num = '0;
        psum_valid = 1'b0; psum_data = 1'b0; m_axis_if.tready = 1'b0;
        pkg_out_valid = 1'b0; pkg_out_last = 1'b0; pkg_out_data = '0;
        pack_buf = '0; pack_n = 0; stage_v = 1'b0; stage_last = 1'b0; stage_data = '0;
        force_v = 1'b0; tb_cnt = 0; exp_w = '0;
        clr_stats();
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_size();
        test_restart_ignored();
        test_reset_mid();
        test_overflow();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_psum_out_ctrl
